spi_ram_ctrl: RTL and testbench
===============================

// Module: spi_ram_ctrl
// PURPOSE
//  Command-decoded single-port RAM behind the SPI slave. Each rx_valid word carries a
//  2-bit opcode plus payload: set write address, write data, set read address, read data.
//  Read data is returned on a valid/ready handshake for SPI MISO serialisation.
//  Parametrised successor of the 8-bit/256-entry RAM, adding backpressure, overflow
//  flagging and optional address auto-increment.
// PARAMETERS
//  DATA_W     8    payload and memory word width
//  ADDR_W     8    address width; must satisfy DATA_W >= ADDR_W
//  MEM_DEPTH  256  number of words; must satisfy MEM_DEPTH <= 2**ADDR_W
// PORTS
//  clk       in   1         rising-edge clock, single domain
//  rst_n     in   1         asynchronous active-low reset
//  din       in   DATA_W+2  [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload
//  rx_valid  in   1         din is valid this cycle; one command consumed per cycle
//  dout      out  DATA_W    read data
//  tx_valid  out  1         dout valid; held until tx_ready
//  tx_ready  in   1         SPI slave accepts dout this cycle
//  rd_ovf    out  1         sticky: a read was dropped while tx was pending
// BEHAVIOUR
//  Reset (async assert, sync deassert by upstream): dout=0, tx_valid=0, rd_ovf=0,
//   wr_addr=0, rd_addr=0, FSM=IDLE. Memory contents are not reset.
//  Opcodes, acted on only when rx_valid=1:
//   00 WR_ADDR  wr_addr <= din[ADDR_W-1:0]
//   01 WR_DATA  mem[wr_addr] <= payload
//   10 RD_ADDR  rd_addr <= din[ADDR_W-1:0]
//   11 RD_DATA  issue a read of mem[rd_addr]
//  FSM states:
//   IDLE: RD_DATA at cycle N -> dout=mem[rd_addr], tx_valid=1 at N+1, go to HOLD.
//   HOLD: dout and tx_valid stay stable until tx_valid&&tx_ready.
//   On the handshake with no new RD_DATA: tx_valid=0 next cycle, go to IDLE.
//   On the handshake with RD_DATA in the same cycle: load new data, stay in HOLD,
//    tx_valid stays 1.
//   RD_DATA in HOLD without tx_ready: command dropped, rd_addr unchanged, rd_ovf<=1.
//   rd_ovf clears only on reset.
//  Opcodes 00/01/10 are always accepted in any state.
//  WR_DATA followed next cycle by RD_DATA to the same address returns the new data.
//  Out-of-range address (>= MEM_DEPTH): write ignored; read returns 0 with normal
//   handshake.
//  Reset mid-HOLD: tx_valid drops immediately and pending data is discarded.
// CONFIGURATION
//  SPI_RAM_AUTOINC_EN defined:
//   - after each accepted WR_DATA, wr_addr increments.
//   - after each accepted RD_DATA, rd_addr increments.
//   - both wrap from MEM_DEPTH-1 to 0.
//   - a dropped read does not increment.
//  SPI_RAM_AUTOINC_EN undefined: addresses change only via WR_ADDR/RD_ADDR.
// STRUCTURE
//  Package spi_ram_pkg:
//   - opcode localparams OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10,
//     OP_RD_DATA=2'b11
//   - FSM state encoding ST_IDLE, ST_HOLD
//  Sub-module spi_ram_array: DATA_W x MEM_DEPTH storage, synchronous write and
//   registered read, with in-range gating.
//  spi_ram_ctrl owns decode, address registers, FSM and handshake.
// TESTING
//  1 Basic write/read:
//    00_0x05, 01_0xA5, 10_0x05, 11_xx with tx_ready=1
//    -> dout=0xA5 and tx_valid=1 exactly one cycle after the RD_DATA.
//  2 Backpressure:
//    RD_DATA with tx_ready=0 for 5 cycles -> dout and tx_valid held stable.
//    Second RD_DATA during the hold -> dropped, rd_ovf=1.
//    Raise tx_ready -> tx_valid=0 the following cycle.
//  3 Back-to-back reads:
//    handshake and RD_DATA in the same cycle -> tx_valid stays 1, dout updates,
//    rd_ovf stays 0.
//  4 AUTOINC (macro defined):
//    WR_ADDR 0xFE, WR_DATA 0x11/0x22/0x33 -> mem[FE]=11, mem[FF]=22, mem[00]=33.
//    Reads from 0xFE return the same sequence.
//  5 Async reset:
//    assert rst_n mid-HOLD between clock edges -> tx_valid, dout and rd_ovf are 0
//    immediately.
//    Memory retains 0xA5 at address 0x05 after reset.
//  6 MEM_DEPTH=200:
//    write 0x77 to address 210 -> ignored; read of address 210 -> dout=0.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcode constants, FSM state encoding and address wrap helper for the SPI RAM controller.
package spi_ram_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Next address with wrap to 0 after depth-1; out-of-range addresses also restart at 0.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned depth);
        return ((idx + 1) >= depth) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_ram_array.sv
// DATA_W x MEM_DEPTH single-port-style storage: synchronous write, registered read,
// accesses at addresses >= MEM_DEPTH are ignored (writes) or return zero (reads).
module spi_ram_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic [DATA_W-1:0] rd_data_reg;
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

    // Storage is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the held output word, so it only loads on a new read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM behind an SPI slave with valid/ready read return and sticky overflow.
// Build option: define SPI_RAM_AUTOINC_EN to auto-increment addresses after accepted accesses.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              rd_ovf
);

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;
    logic              rd_ovf_reg, rd_ovf_next;

    logic [1:0]        op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wr_cmd;
    logic              rd_cmd;
    logic              rd_accept;
    logic              rd_drop;

    assign op       = din[DATA_W+1:DATA_W];
    assign cmd_addr = din[ADDR_W-1:0];
    assign wr_cmd   = rx_valid && (op == OP_WR_DATA);
    assign rd_cmd   = rx_valid && (op == OP_RD_DATA);

    // A read is taken when the output slot is free or is being emptied this cycle.
    always_comb begin
        state_next = state_reg;
        rd_accept  = 1'b0;
        rd_drop    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rd_cmd) begin
                    rd_accept  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tx_ready) begin
                    if (rd_cmd) begin
                        rd_accept = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (rd_cmd) begin
                    rd_drop = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_addr_next = wr_addr_reg;
        rd_addr_next = rd_addr_reg;
        rd_ovf_next  = rd_ovf_reg | rd_drop;
        if (rx_valid && (op == OP_WR_ADDR)) begin
            wr_addr_next = cmd_addr;
        end else if (wr_cmd && AUTOINC) begin
            wr_addr_next = ADDR_W'(next_index(32'(wr_addr_reg), MEM_DEPTH));
        end
        if (rx_valid && (op == OP_RD_ADDR)) begin
            rd_addr_next = cmd_addr;
        end else if (rd_accept && AUTOINC) begin
            rd_addr_next = ADDR_W'(next_index(32'(rd_addr_reg), MEM_DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            wr_addr_reg <= '0;
            rd_addr_reg <= '0;
            rd_ovf_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_addr_reg <= wr_addr_next;
            rd_addr_reg <= rd_addr_next;
            rd_ovf_reg  <= rd_ovf_next;
        end
    end

    spi_ram_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_cmd),
        .wr_addr(wr_addr_reg),
        .wr_data(din[DATA_W-1:0]),
        .rd_en  (rd_accept),
        .rd_addr(rd_addr_reg),
        .rd_data(dout)
    );

    // tx_valid comes straight off the state register so reset clears it immediately.
    assign tx_valid = (state_reg == ST_HOLD);
    assign rd_ovf   = rd_ovf_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: a 256-deep instance checked against a memory model and
// a 200-deep instance sharing the same stimulus for out-of-range behaviour.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] dout, dout_s;
    logic       tx_valid, tx_valid_s;
    logic       rd_ovf, rd_ovf_s;

    int tests = 0;
    int failed = 0;

    logic [7:0] model_mem [0:255];
    logic [7:0] m_wa = '0;
    logic [7:0] m_ra = '0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_v;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout), .tx_valid(tx_valid), .tx_ready(tx_ready), .rd_ovf(rd_ovf)
    );

    spi_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200)) dut_s (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(dout_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready), .rd_ovf(rd_ovf_s)
    );

    // Inputs change on the falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic [1:0] op, input logic [7:0] pl, input logic vld, input logic rdy);
        din      = {op, pl};
        rx_valid = vld;
        tx_ready = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(2'b00, 8'h00, 1'b0, rdy);
    endtask

    task automatic cmd_wr_addr(input logic [7:0] a, input logic rdy);
        m_wa = a;
        step(OP_WR_ADDR, a, 1'b1, rdy);
    endtask

    task automatic cmd_wr_data(input logic [7:0] d, input logic rdy);
        model_mem[m_wa] = d;
        if (AUTOINC) m_wa = m_wa + 8'd1;
        step(OP_WR_DATA, d, 1'b1, rdy);
    endtask

    task automatic cmd_rd_addr(input logic [7:0] a, input logic rdy);
        m_ra = a;
        step(OP_RD_ADDR, a, 1'b1, rdy);
    endtask

    task automatic cmd_rd_data(input logic rdy, input logic accepted);
        if (accepted) begin
            exp_q.push_back(model_mem[m_ra]);
            if (AUTOINC) m_ra = m_ra + 8'd1;
        end
        step(OP_RD_DATA, 8'h00, 1'b1, rdy);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (tx_valid !== 1'b0) begin failed++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        tests++;
        if (dout !== 8'h00) begin failed++; $display("FAIL reset_dout got=%h want=00", dout); end
        tests++;
        if (rd_ovf !== 1'b0) begin failed++; $display("FAIL reset_rd_ovf got=%b want=0", rd_ovf); end
        rst_n = 1'b1;
        idle(1'b0);
        tests++;
        if (tx_valid !== 1'b0 || rd_ovf !== 1'b0) begin
            failed++; $display("FAIL reset_release tx_valid=%b rd_ovf=%b want 0/0", tx_valid, rd_ovf);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        cmd_wr_addr(8'h05, 1'b1);
        cmd_wr_data(8'hA5, 1'b1);
        cmd_rd_addr(8'h05, 1'b1);
        tests++;
        if (tx_valid !== 1'b0) begin failed++; $display("FAIL basic_early_valid got=%b want=0", tx_valid); end
        cmd_rd_data(1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++; $display("FAIL basic_read dout=%h tx_valid=%b want %h/1", dout, tx_valid, exp_v);
        end
        $display("[TB] basic read addr 05 dout=%h", dout);
        idle(1'b1);
        tests++;
        if (tx_valid !== 1'b0) begin failed++; $display("FAIL basic_release got=%b want=0", tx_valid); end
        // write immediately followed by a read of the same location
        cmd_rd_addr(8'h30, 1'b1);
        cmd_wr_addr(8'h30, 1'b1);
        cmd_wr_data(8'h5C, 1'b1);
        cmd_rd_data(1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++; $display("FAIL wr_then_rd dout=%h tx_valid=%b want %h/1", dout, tx_valid, exp_v);
        end
        $display("[TB] write-then-read addr 30 dout=%h", dout);
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        cmd_wr_addr(8'h10, 1'b0);
        cmd_wr_data(8'h3C, 1'b0);
        cmd_wr_addr(8'h11, 1'b0);
        cmd_wr_data(8'h4D, 1'b0);
        cmd_rd_addr(8'h10, 1'b0);
        cmd_rd_data(1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++; $display("FAIL b2b_first dout=%h tx_valid=%b want %h/1", dout, tx_valid, exp_v);
        end
        cmd_rd_addr(8'h11, 1'b0);
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++; $display("FAIL b2b_hold dout=%h tx_valid=%b want %h/1", dout, tx_valid, exp_v);
        end
        cmd_rd_data(1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v || rd_ovf !== 1'b0) begin
            failed++;
            $display("FAIL b2b_second dout=%h tx_valid=%b rd_ovf=%b want %h/1/0", dout, tx_valid, rd_ovf, exp_v);
        end
        $display("[TB] back-to-back read dout=%h", dout);
        idle(1'b1);
        tests++;
        if (tx_valid !== 1'b0 || rd_ovf !== 1'b0) begin
            failed++; $display("FAIL b2b_release tx_valid=%b rd_ovf=%b want 0/0", tx_valid, rd_ovf);
        end
    endtask

    task automatic test_backpressure();
        cmd_rd_addr(8'h05, 1'b0);
        cmd_rd_data(1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++; $display("FAIL bp_first dout=%h tx_valid=%b want %h/1", dout, tx_valid, exp_v);
        end
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            tests++;
            if (tx_valid !== 1'b1 || dout !== exp_v) begin
                failed++; $display("FAIL bp_hold%0d dout=%h tx_valid=%b want %h/1", i, dout, tx_valid, exp_v);
            end
        end
        cmd_rd_data(1'b0, 1'b0);
        tests++;
        if (rd_ovf !== 1'b1 || tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++;
            $display("FAIL bp_drop rd_ovf=%b tx_valid=%b dout=%h want 1/1/%h", rd_ovf, tx_valid, dout, exp_v);
        end
        $display("[TB] dropped read, rd_ovf=%b dout=%h", rd_ovf, dout);
        idle(1'b1);
        tests++;
        if (tx_valid !== 1'b0) begin failed++; $display("FAIL bp_release got=%b want=0", tx_valid); end
        idle(1'b0);
        tests++;
        if (rd_ovf !== 1'b1) begin failed++; $display("FAIL bp_sticky got=%b want=1", rd_ovf); end
        tests++;
        if (exp_q.size() != 0) begin failed++; $display("FAIL bp_queue size=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_autoinc();
        cmd_wr_addr(8'hFE, 1'b0);
        cmd_wr_data(8'h11, 1'b0);
        cmd_wr_data(8'h22, 1'b0);
        cmd_wr_data(8'h33, 1'b0);
        cmd_rd_addr(8'hFE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cmd_rd_data(1'b1, 1'b1);
            exp_v = exp_q.pop_front();
            tests++;
            if (tx_valid !== 1'b1 || dout !== exp_v) begin
                failed++; $display("FAIL autoinc_rd%0d dout=%h tx_valid=%b want %h/1", i, dout, tx_valid, exp_v);
            end
            $display("[TB] autoinc=%0d read %0d dout=%h", AUTOINC, i, dout);
        end
        idle(1'b1);
        tests++;
        if (tx_valid !== 1'b0) begin failed++; $display("FAIL autoinc_release got=%b want=0", tx_valid); end
    endtask

    task automatic test_async_reset();
        cmd_rd_addr(8'h05, 1'b0);
        cmd_rd_data(1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++; $display("FAIL ar_hold dout=%h tx_valid=%b want %h/1", dout, tx_valid, exp_v);
        end
        cmd_rd_data(1'b0, 1'b0);
        din = '0;
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 1'b0) begin failed++; $display("FAIL ar_tx_valid got=%b want=0", tx_valid); end
        tests++;
        if (dout !== 8'h00) begin failed++; $display("FAIL ar_dout got=%h want=00", dout); end
        tests++;
        if (rd_ovf !== 1'b0) begin failed++; $display("FAIL ar_rd_ovf got=%b want=0", rd_ovf); end
        $display("[TB] async reset mid-hold tx_valid=%b dout=%h rd_ovf=%b", tx_valid, dout, rd_ovf);
        @(negedge clk);
        rst_n = 1'b1;
        m_wa = '0;
        m_ra = '0;
        exp_q.delete();
        cmd_rd_addr(8'h05, 1'b1);
        cmd_rd_data(1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid !== 1'b1 || dout !== exp_v) begin
            failed++; $display("FAIL ar_retain dout=%h tx_valid=%b want %h/1", dout, tx_valid, exp_v);
        end
        $display("[TB] memory after reset addr 05 dout=%h", dout);
        idle(1'b1);
    endtask

    task automatic test_out_of_range();
        cmd_wr_addr(8'd210, 1'b0);
        cmd_wr_data(8'h77, 1'b0);
        cmd_wr_addr(8'd199, 1'b0);
        cmd_wr_data(8'h66, 1'b0);
        cmd_rd_addr(8'd210, 1'b1);
        cmd_rd_data(1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid_s !== 1'b1 || dout_s !== 8'h00) begin
            failed++; $display("FAIL oor_read dout=%h tx_valid=%b want 00/1", dout_s, tx_valid_s);
        end
        tests++;
        if (dout !== exp_v) begin failed++; $display("FAIL oor_full_read dout=%h want %h", dout, exp_v); end
        $display("[TB] depth200 read addr 210 dout=%h", dout_s);
        cmd_rd_addr(8'd199, 1'b1);
        cmd_rd_data(1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        tests++;
        if (tx_valid_s !== 1'b1 || dout_s !== 8'h66) begin
            failed++; $display("FAIL oor_last_read dout=%h tx_valid=%b want 66/1", dout_s, tx_valid_s);
        end
        tests++;
        if (dout !== exp_v) begin failed++; $display("FAIL oor_full_last dout=%h want %h", dout, exp_v); end
        $display("[TB] depth200 read addr 199 dout=%h", dout_s);
        idle(1'b1);
        tests++;
        if (tx_valid_s !== 1'b0) begin failed++; $display("FAIL oor_release got=%b want=0", tx_valid_s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_autoinc();
        test_async_reset();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
